alu_arbiter: RTL and testbench

Shares the single combinational 32-bit `alu` instance of the multi-cycle datapath between two requesters, e.g. the main control FSM (req0) and an address/branch-target helper (req1). Each requester hands over operands and an ALU operation code through a valid/ready handshake. The arbiter grants one requester at a time, either round-robin or with fixed priority. It sequences the ALU through an IDLE/EXEC/RESP state machine, registers the result and Zero flag, and returns them with the winning requester's id.

---
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the signals that connect the ALU arbiter to its surroundings:
//   req0_* / req1_*  : operand/opcode handshakes from the two requesters
//   alu_*            : operands out to, and result/zero flag back from,
//                      the shared combinational ALU
//   rsp_*            : registered result handshake towards the consumer
//   busy             : the arbiter is executing or holding a response
// slave  : arbiter side
// master : environment side (requesters, ALU, consumer)
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_A;
    logic [31:0] req0_B;
    logic [31:0] req1_A;
    logic [31:0] req1_B;
    logic [3:0]  req0_Op;
    logic [3:0]  req1_Op;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_Op;
    logic [31:0] alu_C;
    logic        alu_Zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_C;
    logic        rsp_Zero;
    logic        rsp_id;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_A, req0_B, req1_A, req1_B,
        input  req0_Op, req1_Op, alu_C, alu_Zero, rsp_ready,
        output req0_ready, req1_ready, alu_A, alu_B, alu_Op,
        output rsp_valid, rsp_C, rsp_Zero, rsp_id, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_A, req0_B, req1_A, req1_B,
        output req0_Op, req1_Op, alu_C, alu_Zero, rsp_ready,
        input  req0_ready, req1_ready, alu_A, alu_B, alu_Op,
        input  rsp_valid, rsp_C, rsp_Zero, rsp_id, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational 32-bit ALU between two requesters. One request
// is granted at a time (round-robin or fixed priority), its operands are
// latched and held on the ALU for one cycle, and the result plus Zero flag
// are registered and returned together with the id of the winning requester.
//
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   alu_arbiter_if.slave (request handshakes, ALU drive/return,
//         response handshake, busy)
//
// PRIO_MODE: 0 = round-robin, 1 = req0 always wins.
//
// state | meaning
// IDLE  | arbitrate; at most one ready raised, accept latches operands
// EXEC  | latched operands on the ALU; result captured at the edge
// RESP  | rsp_valid high; held until rsp_ready
module alu_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic   clk,
    input  logic   rstn,
    alu_arbiter_if.slave bus
);

    localparam logic [3:0] ALU_NOP = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_grant_q;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [3:0]  op_op_q;
    logic [31:0] rsp_c_q;
    logic        rsp_zero_q;
    logic        rsp_id_q;

    // Grants are only ever raised in IDLE. rstn gates them so no ready can
    // leak out while reset is held, even though the state already reads IDLE.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && rstn) begin
            if (PRIO_MODE != 0) begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid & ~bus.req0_valid;
            end else if (bus.req0_valid && bus.req1_valid) begin
                // Contest: the requester that did not win last time wins.
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt0 || gnt1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_op_q      <= ALU_NOP;
            rsp_c_q      <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                op_a_q       <= gnt1 ? bus.req1_A  : bus.req0_A;
                op_b_q       <= gnt1 ? bus.req1_B  : bus.req0_B;
                op_op_q      <= gnt1 ? bus.req1_Op : bus.req0_Op;
                rsp_id_q     <= gnt1;
                last_grant_q <= gnt1;
            end
            if (state_q == EXEC) begin
                rsp_c_q    <= bus.alu_C;
                rsp_zero_q <= bus.alu_Zero;
            end
        end
    end

    // The ALU is fed straight from the operand latch, so its inputs keep
    // their last values until the next accept.
    assign bus.alu_A      = op_a_q;
    assign bus.alu_B      = op_b_q;
    assign bus.alu_Op     = op_op_q;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_C      = rsp_c_q;
    assign bus.rsp_Zero   = rsp_zero_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_pass;

    // model state: which requester won the most recent accept, per DUT
    bit   m_last_rr;
    bit   m_last_fp;

    alu_arbiter_if if_rr ();
    alu_arbiter_if if_fp ();

    alu_arbiter #(.PRIO_MODE(0)) u_rr (.clk(clk), .rstn(rstn), .bus(if_rr.slave));
    alu_arbiter #(.PRIO_MODE(1)) u_fp (.clk(clk), .rstn(rstn), .bus(if_fp.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // shared ALU stand-in for each DUT
    assign if_rr.alu_C    = alu_f(if_rr.alu_A, if_rr.alu_B, if_rr.alu_Op);
    assign if_rr.alu_Zero = (if_rr.alu_C == 32'd0);
    assign if_fp.alu_C    = alu_f(if_fp.alu_A, if_fp.alu_B, if_fp.alu_Op);
    assign if_fp.alu_Zero = (if_fp.alu_C == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // -1 = no grant, otherwise the winning requester
    function automatic int exp_grant(input bit prio, input bit last, input bit v0, input bit v1);
        if (!v0 && !v1) return -1;
        if (prio)       return v0 ? 0 : 1;
        if (v0 && v1)   return last ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    task automatic drive(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1);
        if_rr.req0_valid = v0; if_fp.req0_valid = v0;
        if_rr.req1_valid = v1; if_fp.req1_valid = v1;
        if_rr.req0_A = a0; if_fp.req0_A = a0;
        if_rr.req0_B = b0; if_fp.req0_B = b0;
        if_rr.req0_Op = o0; if_fp.req0_Op = o0;
        if_rr.req1_A = a1; if_fp.req1_A = a1;
        if_rr.req1_B = b1; if_fp.req1_B = b1;
        if_rr.req1_Op = o1; if_fp.req1_Op = o1;
    endtask

    task automatic set_rsp_ready(input logic r);
        if_rr.rsp_ready = r;
        if_fp.rsp_ready = r;
    endtask

    task automatic chk_resp(input string t, input logic rv, input logic [31:0] c, input logic z,
                            input logic id, input logic r0, input logic r1,
                            input logic [31:0] ec, input logic eid);
        chk({t, "_rsp_valid"}, {31'd0, rv}, 32'd1);
        chk({t, "_rsp_C"},     c, ec);
        chk({t, "_rsp_Zero"},  {31'd0, z}, {31'd0, (ec == 32'd0)});
        chk({t, "_rsp_id"},    {31'd0, id}, {31'd0, eid});
        chk({t, "_rdy_resp"},  {30'd0, r1, r0}, 32'd0);
    endtask

    // One transaction: present requests in an IDLE cycle, check the grant,
    // the EXEC cycle, the response 2 cycles after accept, optional stall,
    // and the drop of rsp_valid after the consumer takes it.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                          input int stall);
        int          g_rr;
        int          g_fp;
        logic [31:0] ea_rr, eb_rr, ea_fp, eb_fp, ec_rr, ec_fp;
        logic [3:0]  eo_rr, eo_fp;
        @(negedge clk);
        drive(v0, v1, a0, b0, o0, a1, b1, o1);
        set_rsp_ready(1'b0);
        #1;
        g_rr = exp_grant(1'b0, m_last_rr, v0, v1);
        g_fp = exp_grant(1'b1, m_last_fp, v0, v1);
        chk("rr_grant", {30'd0, if_rr.req1_ready, if_rr.req0_ready},
            (g_rr < 0) ? 32'd0 : (g_rr == 0 ? 32'd1 : 32'd2));
        chk("fp_grant", {30'd0, if_fp.req1_ready, if_fp.req0_ready},
            (g_fp < 0) ? 32'd0 : (g_fp == 0 ? 32'd1 : 32'd2));
        if (g_rr < 0) begin
            @(posedge clk); #1;
            chk("idle_busy", {30'd0, if_fp.busy, if_rr.busy}, 32'd0);
            return;
        end
        ea_rr = (g_rr == 1) ? a1 : a0;  eb_rr = (g_rr == 1) ? b1 : b0;  eo_rr = (g_rr == 1) ? o1 : o0;
        ea_fp = (g_fp == 1) ? a1 : a0;  eb_fp = (g_fp == 1) ? b1 : b0;  eo_fp = (g_fp == 1) ? o1 : o0;
        ec_rr = alu_f(ea_rr, eb_rr, eo_rr);
        ec_fp = alu_f(ea_fp, eb_fp, eo_fp);
        m_last_rr = (g_rr == 1);
        m_last_fp = (g_fp == 1);

        @(posedge clk); #1;
        chk("exec_busy",  {30'd0, if_fp.busy, if_rr.busy}, 32'd3);
        chk("exec_rv",    {30'd0, if_fp.rsp_valid, if_rr.rsp_valid}, 32'd0);
        chk("exec_rdy",   {28'd0, if_fp.req1_ready, if_fp.req0_ready,
                           if_rr.req1_ready, if_rr.req0_ready}, 32'd0);
        chk("rr_alu_A",   if_rr.alu_A, ea_rr);
        chk("rr_alu_B",   if_rr.alu_B, eb_rr);
        chk("rr_alu_Op",  {28'd0, if_rr.alu_Op}, {28'd0, eo_rr});
        chk("fp_alu_A",   if_fp.alu_A, ea_fp);
        chk("fp_alu_Op",  {28'd0, if_fp.alu_Op}, {28'd0, eo_fp});

        @(posedge clk); #1;
        chk_resp("rr", if_rr.rsp_valid, if_rr.rsp_C, if_rr.rsp_Zero, if_rr.rsp_id,
                 if_rr.req0_ready, if_rr.req1_ready, ec_rr, (g_rr == 1));
        chk_resp("fp", if_fp.rsp_valid, if_fp.rsp_C, if_fp.rsp_Zero, if_fp.rsp_id,
                 if_fp.req0_ready, if_fp.req1_ready, ec_fp, (g_fp == 1));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk_resp("rr_hold", if_rr.rsp_valid, if_rr.rsp_C, if_rr.rsp_Zero, if_rr.rsp_id,
                     if_rr.req0_ready, if_rr.req1_ready, ec_rr, (g_rr == 1));
            chk_resp("fp_hold", if_fp.rsp_valid, if_fp.rsp_C, if_fp.rsp_Zero, if_fp.rsp_id,
                     if_fp.req0_ready, if_fp.req1_ready, ec_fp, (g_fp == 1));
        end
        set_rsp_ready(1'b1);
        @(posedge clk); #1;
        set_rsp_ready(1'b0);
        chk("rsp_drop", {30'd0, if_fp.rsp_valid, if_rr.rsp_valid}, 32'd0);
        chk("idle_busy", {30'd0, if_fp.busy, if_rr.busy}, 32'd0);
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return OP_ADD;
            1:       return OP_SUB;
            2:       return OP_AND;
            3:       return OP_OR;
            default: return OP_SLT;
        endcase
    endfunction

    initial begin
        n_chk = 0;
        n_pass = 0;
        m_last_rr = 1'b1;
        m_last_fp = 1'b1;
        rstn = 1'b0;
        set_rsp_ready(1'b0);
        // requests held high during reset must not be granted
        drive(1'b1, 1'b1, 32'd9, 32'd9, OP_ADD, 32'd9, 32'd9, OP_ADD);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",   {28'd0, if_fp.req1_ready, if_fp.req0_ready,
                          if_rr.req1_ready, if_rr.req0_ready}, 32'd0);
        chk("rst_rv",    {31'd0, if_rr.rsp_valid}, 32'd0);
        chk("rst_busy",  {31'd0, if_rr.busy}, 32'd0);
        chk("rst_C",     if_rr.rsp_C, 32'd0);
        chk("rst_id",    {31'd0, if_rr.rsp_id}, 32'd0);
        chk("rst_alu_A", if_rr.alu_A, 32'd0);
        chk("rst_alu_Op", {28'd0, if_rr.alu_Op}, {28'd0, OP_NOP});
        drive(1'b0, 1'b0, 32'd0, 32'd0, OP_NOP, 32'd0, 32'd0, OP_NOP);
        rstn = 1'b1;

        run_op(1'b1, 1'b0, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_NOP, 0);
        run_op(1'b0, 1'b1, 32'd0, 32'd0, OP_NOP, 32'd3, 32'd3, OP_SUB, 0);
        // both continuously valid: rr alternates 0,1,0,1; fp always 0
        for (int i = 0; i < 4; i++)
            run_op(1'b1, 1'b1, 32'hF0, 32'h0F, OP_OR, 32'hFFFF_FFFF, 32'd1, OP_SLT, 0);
        // backpressure
        run_op(1'b1, 1'b1, 32'd100, 32'd1, OP_SUB, 32'd6, 32'd3, OP_AND, 5);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a0, b0, a1, b1;
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   a0, b0, rand_op(), a1, b1, rand_op(), $urandom_range(0, 3));
        end

        // Reset mid-op: make req0 the last rr winner so a surviving
        // last_grant would hand the next contest to req1.
        run_op(1'b1, 1'b0, 32'd1, 32'd1, OP_ADD, 32'd0, 32'd0, OP_NOP, 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'd11, 32'd22, OP_ADD, 32'd33, 32'd44, OP_ADD);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {30'd0, if_fp.busy, if_rr.busy}, 32'd0);
        chk("mid_rst_rv",   {30'd0, if_fp.rsp_valid, if_rr.rsp_valid}, 32'd0);
        chk("mid_rst_rdy",  {28'd0, if_fp.req1_ready, if_fp.req0_ready,
                             if_rr.req1_ready, if_rr.req0_ready}, 32'd0);
        chk("mid_rst_alu_A", if_rr.alu_A, 32'd0);
        chk("mid_rst_alu_Op", {28'd0, if_rr.alu_Op}, {28'd0, OP_NOP});
        chk("mid_rst_C",    if_rr.rsp_C, 32'd0);
        m_last_rr = 1'b1;
        m_last_fp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_rsp", {30'd0, if_fp.rsp_valid, if_rr.rsp_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, OP_NOP, 32'd0, 32'd0, OP_NOP);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rv", {30'd0, if_fp.rsp_valid, if_rr.rsp_valid}, 32'd0);
        run_op(1'b1, 1'b1, 32'd11, 32'd22, OP_ADD, 32'd33, 32'd44, OP_ADD, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
